matrix_mult_par: RTL and testbench

MATRIX_MULT_PAR -- requirements
Module: matrix_mult_par

---
 rtl/matrix_pkg.sv | 16 +
 rtl/matrix_dot_lane.sv | 22 ++
 rtl/matrix_mult_par.sv | 114 +++++++++++
 tb/tb_matrix_mult_par.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the parallel matrix multiplier: FSM states and the
// full-precision result width.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Product is 2*dw bits; summing n of them needs clog2(n) extra bits.
  function automatic int calc_rw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_dot_lane.sv
// One row-by-column dot product of N unsigned DW-bit terms, full precision.
// Term k of each operand sits at bit offset k*DW.
module matrix_dot_lane
  import matrix_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  localparam int RW = calc_rw(N, DW)
) (
  input  logic [N*DW-1:0] row,
  input  logic [N*DW-1:0] col,
  output logic [RW-1:0]   sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum + RW'(row[k*DW +: DW]) * RW'(col[k*DW +: DW]);
    end
  end

endmodule

// File: rtl/matrix_mult_par.sv
// NxN unsigned matrix multiplier: LANES row engines sweep row groups within a
// column, then advance the column; result held until the consumer takes it.
module matrix_mult_par
  import matrix_pkg::*;
#(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int LANES = 2,
  localparam int RW   = calc_rw(N, DW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*N*DW-1:0]   a_in,
  input  logic [N*N*DW-1:0]   b_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*N*RW-1:0]   res,
  output logic                busy
);

  localparam int G  = N / LANES;
  localparam int JW = $clog2(N);
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  generate
    if (N < 2 || (N % LANES) != 0) begin : g_bad_params
      $error("matrix_mult_par: need N >= 2 and LANES dividing N");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [JW-1:0]       j_reg;
  logic [GW-1:0]       g_reg;
  logic [N*N*DW-1:0]   a_reg, b_reg;
  logic [N*N*RW-1:0]   res_reg;
  logic [RW-1:0]       lane_sum [LANES];
  logic                last_step;

  assign last_step = (j_reg == JW'(N - 1)) && (g_reg == GW'(G - 1));
  assign res       = res_reg;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = COMPUTE;
      COMPUTE: if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == DONE);
  end

  // Operand capture, schedule counters and result writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      j_reg   <= '0;
      g_reg   <= '0;
    end else if (state_reg == IDLE && in_valid) begin
      a_reg <= a_in;
      b_reg <= b_in;
      j_reg <= '0;
      g_reg <= '0;
    end else if (state_reg == COMPUTE) begin
      for (int l = 0; l < LANES; l++) begin
        res_reg[(N*N - 1 - ((int'(g_reg) * LANES + l) * N + int'(j_reg))) * RW +: RW] <= lane_sum[l];
      end
      if (g_reg == GW'(G - 1)) begin
        g_reg <= '0;
        j_reg <= j_reg + 1'b1;
      end else begin
        g_reg <= g_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [N*DW-1:0] row_vec, col_vec;

      // Lane gi handles row g*LANES+gi against column j.
      always_comb begin
        row_vec = '0;
        col_vec = '0;
        for (int k = 0; k < N; k++) begin
          row_vec[k*DW +: DW] = a_reg[(N*N - 1 - ((int'(g_reg) * LANES + gi) * N + k)) * DW +: DW];
          col_vec[k*DW +: DW] = b_reg[(N*N - 1 - (k * N + int'(j_reg))) * DW +: DW];
        end
      end

      matrix_dot_lane #(.N(N), .DW(DW)) u_lane (
        .row (row_vec),
        .col (col_vec),
        .sum (lane_sum[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_matrix_mult_par.sv
// Directed bench: 2x2 table vectors plus handshake, reset and back-to-back
// sequences, and 4x4 runs with one and four lanes.
module tb_matrix_mult_par;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         iv2 = 1'b0, or2 = 1'b1;
  logic [31:0]  a2 = '0, b2 = '0;
  logic         ir2, ov2, busy2;
  logic [67:0]  res2;

  logic         iv4a = 1'b0, iv4b = 1'b0, or4 = 1'b1;
  logic [127:0] a4 = '0, b4 = '0;
  logic         ir4a, ov4a, busy4a, ir4b, ov4b, busy4b;
  logic [287:0] res4a, res4b;

  matrix_mult_par #(.N(2), .DW(8), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_in(a2), .b_in(b2),
    .out_valid(ov2), .out_ready(or2), .res(res2), .busy(busy2));

  matrix_mult_par #(.N(4), .DW(8), .LANES(1)) dut4a (
    .clk(clk), .rst(rst), .in_valid(iv4a), .in_ready(ir4a), .a_in(a4), .b_in(b4),
    .out_valid(ov4a), .out_ready(or4), .res(res4a), .busy(busy4a));

  matrix_mult_par #(.N(4), .DW(8), .LANES(4)) dut4b (
    .clk(clk), .rst(rst), .in_valid(iv4b), .in_ready(ir4b), .a_in(a4), .b_in(b4),
    .out_valid(ov4b), .out_ready(or4), .res(res4b), .busy(busy4b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] p2(input int e0, input int e1, input int e2, input int e3);
    return {8'(e0), 8'(e1), 8'(e2), 8'(e3)};
  endfunction

  function automatic logic [67:0] r2(input int e0, input int e1, input int e2, input int e3);
    return {17'(e0), 17'(e1), 17'(e2), 17'(e3)};
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [67:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic [67:0] exp, input string name);
    int cnt;
    @(negedge clk);
    check({name, " in_ready"}, 288'(ir2), 288'(1));
    iv2 = 1'b1; a2 = a; b2 = b;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    check({name, " busy"}, 288'(busy2), 288'(1));
    cnt = 0;
    while (!ov2 && cnt < 20) begin
      @(posedge clk); cnt++;
      @(negedge clk);
    end
    check({name, " latency"}, 288'(cnt), 288'(2));
    check({name, " res"}, 288'(res2), 288'(exp));
    $display("op %s: latency=%0d res=%h", name, cnt, res2);
    @(posedge clk);
    @(negedge clk);
    check({name, " out_valid drop"}, 288'(ov2), 288'(0));
    check({name, " in_ready back"}, 288'(ir2), 288'(1));
  endtask

  task automatic run4(input bit sel, input logic [127:0] a, input logic [127:0] b,
                      input logic [287:0] exp, input int lat, input string name);
    int cnt;
    @(negedge clk);
    a4 = a; b4 = b;
    if (sel) iv4b = 1'b1; else iv4a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4a = 1'b0; iv4b = 1'b0;
    cnt = 0;
    while (!(sel ? ov4b : ov4a) && cnt < 40) begin
      @(posedge clk); cnt++;
      @(negedge clk);
    end
    check({name, " latency"}, 288'(cnt), 288'(lat));
    check({name, " res"}, sel ? res4b : res4a, exp);
    $display("op %s: latency=%0d res=%h", name, cnt, sel ? res4b : res4a);
    @(posedge clk);
    @(negedge clk);
    check({name, " out_valid drop"}, 288'(sel ? ov4b : ov4a), 288'(0));
  endtask

  initial begin
    logic [127:0] a_id, a_one, b_seq;
    logic [287:0] e_id, e_one;
    logic [67:0]  held;

    vecs[0] = '{a: p2(1, 2, 3, 4),         b: p2(5, 6, 7, 8),       exp: r2(19, 22, 43, 50)};
    vecs[1] = '{a: p2(255, 255, 255, 255), b: p2(255, 255, 255, 255),
                exp: r2(130050, 130050, 130050, 130050)};
    vecs[2] = '{a: p2(1, 0, 0, 1),         b: p2(9, 8, 7, 6),       exp: r2(9, 8, 7, 6)};
    vecs[3] = '{a: p2(0, 0, 0, 0),         b: p2(11, 22, 33, 44),   exp: r2(0, 0, 0, 0)};
    vecs[4] = '{a: p2(2, 0, 0, 3),         b: p2(10, 20, 30, 40),   exp: r2(20, 40, 90, 120)};
    vecs[5] = '{a: p2(255, 1, 0, 2),       b: p2(255, 0, 3, 4),     exp: r2(65028, 4, 6, 8)};

    a_id = '0; a_one = '0; b_seq = '0; e_id = '0; e_one = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a_id[(15 - (r*4 + c))*8 +: 8]   = (r == c) ? 8'd1 : 8'd0;
        a_one[(15 - (r*4 + c))*8 +: 8]  = 8'd1;
        b_seq[(15 - (r*4 + c))*8 +: 8]  = 8'(r*4 + c);
        e_id[(15 - (r*4 + c))*18 +: 18] = 18'(r*4 + c);
        e_one[(15 - (r*4 + c))*18 +: 18] = 18'(24 + 4*c);
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 288'(ov2), 288'(0));
    check("reset busy", 288'(busy2), 288'(0));
    check("reset res", 288'(res2), 288'(0));
    check("reset res4a", res4a, 288'(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after reset", 288'(ir2), 288'(1));

    for (int i = 0; i < 6; i++) run2(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Consumer stalls in DONE; new operands must be ignored
    @(negedge clk);
    or2 = 1'b0; iv2 = 1'b1; a2 = p2(1, 2, 3, 4); b2 = p2(5, 6, 7, 8);
    @(posedge clk);
    @(negedge clk);
    a2 = p2(9, 9, 9, 9); b2 = p2(9, 9, 9, 9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    held = r2(19, 22, 43, 50);
    check("hold enter DONE", 288'(ov2), 288'(1));
    check("hold res", 288'(res2), 288'(held));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d out_valid", i), 288'(ov2), 288'(1));
      check($sformatf("hold%0d res", i), 288'(res2), 288'(held));
      check($sformatf("hold%0d in_ready", i), 288'(ir2), 288'(0));
    end
    iv2 = 1'b0; or2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release out_valid", 288'(ov2), 288'(0));
    check("release in_ready", 288'(ir2), 288'(1));
    check("release res kept", 288'(res2), 288'(held));
    $display("op hold: res=%h", res2);

    // Reset one cycle into COMPUTE aborts the operation
    iv2 = 1'b1; a2 = p2(3, 3, 3, 3); b2 = p2(3, 3, 3, 3);
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort out_valid", 288'(ov2), 288'(0));
    check("abort res", 288'(res2), 288'(0));
    check("abort in_ready", 288'(ir2), 288'(1));
    check("abort busy", 288'(busy2), 288'(0));
    $display("op abort: res=%h", res2);
    run2(p2(1, 2, 3, 4), p2(5, 6, 7, 8), r2(19, 22, 43, 50), "after_abort");

    // Back-to-back with in_valid held high
    @(negedge clk);
    iv2 = 1'b1; a2 = p2(1, 2, 3, 4); b2 = p2(5, 6, 7, 8);
    @(posedge clk);
    @(negedge clk);
    a2 = p2(2, 0, 0, 3); b2 = p2(10, 20, 30, 40);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b2b first valid", 288'(ov2), 288'(1));
    check("b2b first res", 288'(res2), 288'(r2(19, 22, 43, 50)));
    check("b2b no accept in DONE", 288'(ir2), 288'(0));
    $display("op b2b_first: res=%h", res2);
    @(posedge clk);
    @(negedge clk);
    check("b2b idle gap valid", 288'(ov2), 288'(0));
    check("b2b idle gap in_ready", 288'(ir2), 288'(1));
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    check("b2b second accepted", 288'(busy2), 288'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b2b second valid", 288'(ov2), 288'(1));
    check("b2b second res", 288'(res2), 288'(r2(20, 40, 90, 120)));
    $display("op b2b_second: res=%h", res2);

    // 4x4 with one lane and with four lanes
    run4(1'b0, a_id,  b_seq, e_id,  16, "n4_l1_identity");
    run4(1'b0, a_one, b_seq, e_one, 16, "n4_l1_ones");
    run4(1'b1, a_id,  b_seq, e_id,  4,  "n4_l4_identity");
    run4(1'b1, a_one, b_seq, e_one, 4,  "n4_l4_ones");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
